// File: rtl/control_sequencer.sv
// Multi-cycle Moore control unit for the 32-bit register/bus datapath: fetch, opcode decode,
// execute sequencing and a timed req/ack memory handshake that halts with a sticky fault.
module control_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic [31:0] i_ir,
    input  logic        i_mem_ack,
    output logic [15:0] o_R_in,
    output logic [15:0] o_R_out,
    output logic        o_PCout,
    output logic        o_IncPC,
    output logic        o_MARin,
    output logic        o_MDRin,
    output logic        o_MDRread,
    output logic        o_MDRout,
    output logic        o_IRin,
    output logic        o_Yin,
    output logic        o_Zin,
    output logic        o_ZLowout,
    output logic        o_ZHighout,
    output logic        o_HIin,
    output logic        o_LOin,
    output logic        o_Cout,
    output logic [3:0]  o_ALUselect,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_run,
    output logic        o_fault,
    output logic        o_illegal
);
    localparam int unsigned CNT_W = 8;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;

    logic [4:0]  w_op;
    logic [15:0] w_ra_oh;
    logic [15:0] w_rb_oh;
    logic [15:0] w_rc_oh;
    logic        w_unused_ir;
    logic        w_is_rrr;
    logic        w_is_addi;
    logic        w_is_arith;
    logic        w_is_md;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_is_mem;
    logic        w_is_nop;
    logic        w_is_halt;
    logic        w_is_illegal;
    logic        w_wait;
    logic [3:0]  w_alu_sel;

    assign w_op        = i_ir[31:27];
    assign w_ra_oh     = 16'd1 << i_ir[26:23];
    assign w_rb_oh     = 16'd1 << i_ir[22:19];
    assign w_rc_oh     = 16'd1 << i_ir[18:15];
    assign w_unused_ir = ^i_ir[14:0];

    assign w_is_rrr     = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_is_addi    = (w_op == OP_ADDI);
    assign w_is_arith   = w_is_rrr || w_is_addi;
    assign w_is_md      = (w_op == OP_MUL) || (w_op == OP_DIV);
    assign w_is_ld      = (w_op == OP_LD);
    assign w_is_st      = (w_op == OP_ST);
    assign w_is_mem     = w_is_ld || w_is_st;
    assign w_is_nop     = (w_op == OP_NOP);
    assign w_is_halt    = (w_op == OP_HALT);
    assign w_is_illegal = !(w_is_arith || w_is_md || w_is_mem || w_is_nop || w_is_halt);

    // Memory wait states: instruction fetch, load data read, store write.
    assign w_wait = (r_state == S_T1) || ((r_state == S_T6) && w_is_ld) ||
                    ((r_state == S_T7) && w_is_st);

    always_comb begin
        case (w_op)
            OP_SUB:  w_alu_sel = ALU_SUB;
            OP_AND:  w_alu_sel = ALU_AND;
            OP_OR:   w_alu_sel = ALU_OR;
            OP_MUL:  w_alu_sel = ALU_MUL;
            OP_DIV:  w_alu_sel = ALU_DIV;
            default: w_alu_sel = ALU_ADD;
        endcase
    end

    // State, ack timeout counter and sticky fault; an ack in the last counted cycle still wins.
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state <= S_RST;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else if (w_wait && !i_mem_ack) begin
            if (r_cnt <= CNT_W'(1)) begin
                r_state <= S_HALT;
                r_fault <= 1'b1;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else begin
            case (r_state)
                S_RST: r_state <= S_T0;
                S_T0: begin
                    r_state <= S_T1;
                    r_cnt   <= CNT_W'(ACK_TIMEOUT);
                end
                S_T1: r_state <= S_T2;
                S_T2: r_state <= S_T3;
                S_T3: begin
                    if (w_is_halt)                             r_state <= S_HALT;
                    else if (w_is_arith || w_is_md || w_is_mem) r_state <= S_T4;
                    else                                       r_state <= S_T0;
                end
                S_T4: r_state <= S_T5;
                S_T5: begin
                    if (w_is_md || w_is_mem) begin
                        r_state <= S_T6;
                        r_cnt   <= CNT_W'(ACK_TIMEOUT);
                    end else begin
                        r_state <= S_T0;
                    end
                end
                S_T6: begin
                    if (w_is_mem) begin
                        r_state <= S_T7;
                        r_cnt   <= CNT_W'(ACK_TIMEOUT);
                    end else begin
                        r_state <= S_T0;
                    end
                end
                S_T7:    r_state <= S_T0;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RST;
            endcase
        end
    end

    // Moore output decode from state and IR; reset state forces every strobe low at once.
    always_comb begin
        o_R_in      = '0;
        o_R_out     = '0;
        o_PCout     = 1'b0;
        o_IncPC     = 1'b0;
        o_MARin     = 1'b0;
        o_MDRin     = 1'b0;
        o_MDRread   = 1'b0;
        o_MDRout    = 1'b0;
        o_IRin      = 1'b0;
        o_Yin       = 1'b0;
        o_Zin       = 1'b0;
        o_ZLowout   = 1'b0;
        o_ZHighout  = 1'b0;
        o_HIin      = 1'b0;
        o_LOin      = 1'b0;
        o_Cout      = 1'b0;
        o_ALUselect = ALU_ADD;
        o_mem_rd    = 1'b0;
        o_mem_wr    = 1'b0;
        o_illegal   = 1'b0;
        case (r_state)
            S_T0: begin
                o_PCout = 1'b1;
                o_MARin = 1'b1;
                o_IncPC = 1'b1;
            end
            S_T1: begin
                o_mem_rd  = 1'b1;
                o_MDRread = 1'b1;
                o_MDRin   = 1'b1;
            end
            S_T2: begin
                o_MDRout = 1'b1;
                o_IRin   = 1'b1;
            end
            S_T3: begin
                if (w_is_md) begin
                    o_R_out = w_ra_oh;
                    o_Yin   = 1'b1;
                end else if (w_is_arith || w_is_mem) begin
                    o_R_out = w_rb_oh;
                    o_Yin   = 1'b1;
                end
                o_illegal = w_is_illegal;
            end
            S_T4: begin
                if (w_is_rrr || w_is_md) begin
                    o_R_out     = w_is_md ? w_rb_oh : w_rc_oh;
                    o_ALUselect = w_alu_sel;
                    o_Zin       = 1'b1;
                end else if (w_is_addi || w_is_mem) begin
                    o_Cout = 1'b1;
                    o_Zin  = 1'b1;
                end
            end
            S_T5: begin
                if (w_is_arith) begin
                    o_ZLowout = 1'b1;
                    o_R_in    = w_ra_oh;
                end else if (w_is_md) begin
                    o_ZLowout = 1'b1;
                    o_LOin    = 1'b1;
                end else if (w_is_mem) begin
                    o_ZLowout = 1'b1;
                    o_MARin   = 1'b1;
                end
            end
            S_T6: begin
                if (w_is_md) begin
                    o_ZHighout = 1'b1;
                    o_HIin     = 1'b1;
                end else if (w_is_ld) begin
                    o_mem_rd  = 1'b1;
                    o_MDRread = 1'b1;
                    o_MDRin   = 1'b1;
                end else if (w_is_st) begin
                    o_R_out = w_ra_oh;
                    o_MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (w_is_ld) begin
                    o_MDRout = 1'b1;
                    o_R_in   = w_ra_oh;
                end else if (w_is_st) begin
                    o_mem_wr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_run   = (r_state != S_RST) && (r_state != S_HALT);
    assign o_fault = r_fault;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle Moore control unit directly upstream of the 32-bit register/bus datapath: it drives every register enable, bus-source select, ALU operation and memory strobe that the datapath consumes. It runs fetch (T0–T2), decodes the opcode held in the datapath IR, and issues execute steps for ALU, immediate, load/store, mul/div, nop and halt instructions. Memory accesses use a req/ack handshake with a timeout.

## Interface
- ACK_TIMEOUT, 15: max cycles to wait for `mem_ack` before faulting (1..255).
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-low
- ir  in  32  current IR contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15]
- mem_ack  in  1  memory completes current read/write this cycle
- R_in  out  16  one-hot register load enable (bit n = Rn)
- R_out  out  16  one-hot register bus drive (bit n = Rn)
- PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin, Zin, ZLowout, ZHighout, HIin, LOin, Cout  out  1 each  datapath strobes
- ALUselect  out  4  add 0000, sub 0001, and 0010, or 0011, mul 0100, div 0101
- mem_rd, mem_wr  out  1 each  memory request, held until ack
- run  out  1  high while executing
- fault  out  1  sticky: ack timeout
- illegal  out  1  one-cycle pulse on unknown opcode

## Operation
- Outputs decoded combinationally from state register and `ir` only (never from `mem_ack`); unlisted outputs 0 in every state; ALUselect 0000 unless listed.
- Opcodes: ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01000, mul 01110, div 01111, nop 11010, halt 11011; all others illegal.
- States: RST, T0–T7, HALT.
- RST: run=0; next T0.
- T0: PCout, MARin, IncPC. T1: mem_rd, MDRread, MDRin; wait. T2: MDRout, IRin. T3 onward per opcode; completion returns to T0.
- add/sub/and/or: T3 R_out[Rb], Yin; T4 R_out[Rc], ALUselect, Zin; T5 ZLowout, R_in[Ra].
- addi: as above but T4 uses Cout instead of R_out[Rc], ALUselect=add.
- mul/div: T3 R_out[Ra], Yin; T4 R_out[Rb], ALUselect, Zin; T5 ZLowout, LOin; T6 ZHighout, HIin.
- ld: T3 R_out[Rb], Yin; T4 Cout, add, Zin; T5 ZLowout, MARin; T6 mem_rd, MDRread, MDRin, wait; T7 MDRout, R_in[Ra].
- st: T3–T5 as ld; T6 R_out[Ra], MDRin (MDRread=0); T7 mem_wr, wait.
- nop: T3 → T0. Illegal: T3 pulses `illegal`, → T0. halt: T3 → HALT.
- HALT: run=0, all strobes 0, remains until clr.
- Wait states: strobes held; advance on edge where mem_ack=1; a down-counter loaded with ACK_TIMEOUT on entry decrements each non-ack cycle; reaching 0 without ack → HALT with fault=1.

## Timing
- clr low: immediately state RST, all outputs 0, run=0, fault=0, counter cleared; no strobe glitch on release; first edge after release → T0.
- Reset mid-wait aborts access; mem_rd/mem_wr drop asynchronously.
- Each strobe valid for full cycle; datapath samples on following rising edge.
- Zero-wait memory (ack in first wait cycle): fetch 3 cycles; ALU 6, mul/div 7, ld/st 8, nop/illegal 4 cycles total. Each extra wait cycle adds one.
- ack in the same cycle the counter hits 0: ack wins, no fault.
- `ir` must be stable from T3 until return to T0 (only IRin in T2 changes it).
- Ra=Rb or Rb=Rc: same one-hot bit, no special case; R0 treated as ordinary register.

## Test plan
- Reset release, ack tied high, ir=add R3,R1,R2 (0x19890000) → T0..T5 in 6 cycles; T4 R_out=0x0004, ALUselect=0000; T5 R_in=0x0008, ZLowout=1.
- ld R5 with Rb=R2, mem_ack delayed 3 cycles in T1 and T6 → mem_rd held 4 cycles each; T7 R_in=0x0020, MDRout=1; total 14 cycles.
- st R4, ack never asserted, ACK_TIMEOUT=15 → after 15 wait cycles in T7 state HALT, fault=1, run=0, mem_wr=0.
- mul R6,R7 → T5 ZLowout+LOin, T6 ZHighout+HIin, ALUselect=0100 in T4; 7 cycles.
- opcode 11111 → illegal pulses one cycle at T3, next T0; then halt opcode → run=0 held 20 cycles.
- clr asserted in T1 wait with mem_rd=1 → mem_rd=0 same cycle, all outputs 0; after release, fetch restarts at T0.
